// File: rtl/brg_rf_read_sequencer_if.sv
// Operand-request, write and RF-macro port bundle for brg_rf_read_sequencer.
// Signal suffixes are from the sequencer's point of view (slave modport).
interface brg_rf_read_sequencer_if #(
  parameter int unsigned width_p      = 32,
  parameter int unsigned addr_width_p = 5
);
  logic                    r_v_i;
  logic                    r_ready_o;
  logic [addr_width_p-1:0] rs1_addr_i;
  logic [addr_width_p-1:0] rs2_addr_i;
  logic                    r_v_o;
  logic [width_p-1:0]      rs1_data_o;
  logic [width_p-1:0]      rs2_data_o;
  logic                    r_yumi_i;
  logic                    w_v_i;
  logic [addr_width_p-1:0] w_addr_i;
  logic [width_p-1:0]      w_data_i;
  logic                    mem_w_v_o;
  logic [addr_width_p-1:0] mem_w_addr_o;
  logic [width_p-1:0]      mem_w_data_o;
  logic                    mem_r_v_o;
  logic [addr_width_p-1:0] mem_r_addr_o;
  logic [width_p-1:0]      mem_r_data_i;

  modport slave (
    input  r_v_i, rs1_addr_i, rs2_addr_i, r_yumi_i, w_v_i, w_addr_i, w_data_i, mem_r_data_i,
    output r_ready_o, r_v_o, rs1_data_o, rs2_data_o,
           mem_w_v_o, mem_w_addr_o, mem_w_data_o, mem_r_v_o, mem_r_addr_o
  );

  modport master (
    output r_v_i, rs1_addr_i, rs2_addr_i, r_yumi_i, w_v_i, w_addr_i, w_data_i, mem_r_data_i,
    input  r_ready_o, r_v_o, rs1_data_o, rs2_data_o,
           mem_w_v_o, mem_w_addr_o, mem_w_data_o, mem_r_v_o, mem_r_addr_o
  );
endinterface

// File: rtl/brg_rf_read_sequencer.sv
// Two-operand RF read sequencer over a 1R1W macro, with write forwarding into in-flight operands.
// Optional: BRG_RF_SEQ_SAME_ADDR_SKIP_EN skips the second macro read when rs1==rs2.
module brg_rf_read_sequencer #(
  parameter  int unsigned width_p       = 32,
  parameter  int unsigned els_p         = 32,
  localparam int unsigned addr_width_lp = $clog2(els_p)
) (
  input logic clk_i,
  input logic reset_i,
  brg_rf_read_sequencer_if.slave rf
);

  typedef enum logic [1:0] {IDLE, RD2, CAP, RESP} state_e;

  state_e                   state_q;
  logic [addr_width_lp-1:0] rs1_addr_q, rs2_addr_q;
  logic [width_p-1:0]       rs1_data_q, rs2_data_q;
  logic                     rs1_fwd_q, rs2_fwd_q;
  logic                     r_v_q;
`ifdef BRG_RF_SEQ_SAME_ADDR_SKIP_EN
  logic                     same_q;
`endif

  logic [addr_width_lp-1:0] op1_addr_c, op2_addr_c;
  logic                     w_ok_c, hit1_c, hit2_c, skip_rd2_c;

  // In the accept cycle the operand addresses come straight from the request.
  assign op1_addr_c = (state_q == IDLE) ? rf.rs1_addr_i : rs1_addr_q;
  assign op2_addr_c = (state_q == IDLE) ? rf.rs2_addr_i : rs2_addr_q;
  assign w_ok_c     = rf.w_v_i && !reset_i && (rf.w_addr_i != '0);
  assign hit1_c     = w_ok_c && (rf.w_addr_i == op1_addr_c);
  assign hit2_c     = w_ok_c && (rf.w_addr_i == op2_addr_c);

`ifdef BRG_RF_SEQ_SAME_ADDR_SKIP_EN
  assign skip_rd2_c = same_q;
`else
  assign skip_rd2_c = 1'b0;
`endif

  assign rf.mem_w_v_o    = w_ok_c;
  assign rf.mem_w_addr_o = rf.w_addr_i;
  assign rf.mem_w_data_o = rf.w_data_i;

  // Macro read port: rs1 in the accept cycle, rs2 in RD2; address 0 never touches the macro.
  always_comb begin
    rf.mem_r_v_o    = 1'b0;
    rf.mem_r_addr_o = rf.rs1_addr_i;
    if (!reset_i) begin
      case (state_q)
        IDLE: begin
          rf.mem_r_v_o    = rf.r_v_i && (rf.rs1_addr_i != '0);
          rf.mem_r_addr_o = rf.rs1_addr_i;
        end
        RD2: begin
          rf.mem_r_v_o    = (rs2_addr_q != '0) && !skip_rd2_c;
          rf.mem_r_addr_o = rs2_addr_q;
        end
        default: ;
      endcase
    end
  end

  assign rf.r_ready_o  = (state_q == IDLE);
  assign rf.r_v_o      = r_v_q;
  assign rf.rs1_data_o = rs1_data_q;
  assign rf.rs2_data_o = rs2_data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_fwd_q  <= 1'b0;
      rs2_fwd_q  <= 1'b0;
      r_v_q      <= 1'b0;
`ifdef BRG_RF_SEQ_SAME_ADDR_SKIP_EN
      same_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (rf.r_v_i) begin
            rs1_addr_q <= rf.rs1_addr_i;
            rs2_addr_q <= rf.rs2_addr_i;
            rs1_fwd_q  <= hit1_c;
            rs2_fwd_q  <= hit2_c;
            rs1_data_q <= hit1_c ? rf.w_data_i : '0;
            rs2_data_q <= hit2_c ? rf.w_data_i : '0;
`ifdef BRG_RF_SEQ_SAME_ADDR_SKIP_EN
            same_q     <= (rf.rs1_addr_i == rf.rs2_addr_i);
`endif
            state_q    <= RD2;
          end
        end
        RD2: begin
          if (hit1_c) begin
            rs1_data_q <= rf.w_data_i;
            rs1_fwd_q  <= 1'b1;
          end else if (!rs1_fwd_q) begin
            rs1_data_q <= (rs1_addr_q == '0) ? '0 : rf.mem_r_data_i;
          end
          if (hit2_c) begin
            rs2_data_q <= rf.w_data_i;
            rs2_fwd_q  <= 1'b1;
          end
          state_q <= CAP;
        end
        CAP: begin
          if (hit1_c) begin
            rs1_data_q <= rf.w_data_i;
            rs1_fwd_q  <= 1'b1;
          end
`ifdef BRG_RF_SEQ_SAME_ADDR_SKIP_EN
          // No rs2 read was issued; mirror the final rs1 value instead.
          if (same_q) begin
            rs2_data_q <= hit1_c ? rf.w_data_i : rs1_data_q;
            rs2_fwd_q  <= hit1_c | rs1_fwd_q;
          end else
`endif
          if (hit2_c) begin
            rs2_data_q <= rf.w_data_i;
            rs2_fwd_q  <= 1'b1;
          end else if (!rs2_fwd_q) begin
            rs2_data_q <= (rs2_addr_q == '0) ? '0 : rf.mem_r_data_i;
          end
          r_v_q   <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (rf.r_yumi_i) begin
            r_v_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brg_rf_read_sequencer.sv
// Directed self-checking bench for brg_rf_read_sequencer with a behavioural 1R1W macro model.
module tb_brg_rf_read_sequencer;

  logic clk = 1'b0;
  logic reset_i;
  int   checks = 0;
  int   failures = 0;

  brg_rf_read_sequencer_if #(.width_p(32), .addr_width_p(5)) rf_if ();

  brg_rf_read_sequencer #(.width_p(32), .els_p(32)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .rf      (rf_if.slave)
  );

  always #5 clk = ~clk;

  // Macro model: data one cycle after the read; a same-cycle write collision returns junk.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (rf_if.mem_r_v_o)
      rf_if.mem_r_data_i <= (rf_if.mem_w_v_o && rf_if.mem_w_addr_o == rf_if.mem_r_addr_o)
                            ? 32'hBAD0_C011 : mem[rf_if.mem_r_addr_o];
    else
      rf_if.mem_r_data_i <= 32'hBAD0_0000;
    if (rf_if.mem_w_v_o) mem[rf_if.mem_w_addr_o] <= rf_if.mem_w_data_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rf_if.r_v_i      = 1'b0;
    rf_if.rs1_addr_i = 5'd0;
    rf_if.rs2_addr_i = 5'd0;
    rf_if.r_yumi_i   = 1'b0;
    rf_if.w_v_i      = 1'b0;
    rf_if.w_addr_i   = 5'd0;
    rf_if.w_data_i   = 32'd0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    rf_if.w_v_i    = 1'b1;
    rf_if.w_addr_i = a;
    rf_if.w_data_i = d;
    #1;
    checks++;
    if (rf_if.mem_w_v_o !== (a != 5'd0)) begin
      failures++;
      $display("FAIL write_v addr=%0d got=%b exp=%b", a, rf_if.mem_w_v_o, (a != 5'd0));
    end
    if (a != 5'd0) begin
      checks++;
      if (rf_if.mem_w_addr_o !== a || rf_if.mem_w_data_o !== d) begin
        failures++;
        $display("FAIL write_fwd got=%0d/%h exp=%0d/%h", rf_if.mem_w_addr_o, rf_if.mem_w_data_o, a, d);
      end
    end
    tick();
    rf_if.w_v_i = 1'b0;
  endtask

  // Accept cycle only; scramble the request addresses afterwards to prove they were latched.
  task automatic accept(input logic [4:0] a1, input logic [4:0] a2);
    rf_if.r_v_i      = 1'b1;
    rf_if.rs1_addr_i = a1;
    rf_if.rs2_addr_i = a2;
    tick();
    rf_if.r_v_i      = 1'b0;
    rf_if.rs1_addr_i = 5'd31;
    rf_if.rs2_addr_i = 5'd31;
  endtask

  task automatic consume(input string name);
    rf_if.r_yumi_i = 1'b1;
    tick();
    rf_if.r_yumi_i = 1'b0;
    checks++;
    if (rf_if.r_v_o !== 1'b0 || rf_if.r_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_consume got v=%b rdy=%b exp v=0 rdy=1", name, rf_if.r_v_o, rf_if.r_ready_o);
    end
  endtask

  task automatic test_reset();
    reset_i          = 1'b1;
    rf_if.w_v_i      = 1'b1;
    rf_if.w_addr_i   = 5'd4;
    rf_if.w_data_i   = 32'h1;
    rf_if.r_v_i      = 1'b1;
    rf_if.rs1_addr_i = 5'd5;
    #1;
    checks++;
    if (rf_if.mem_w_v_o !== 1'b0 || rf_if.mem_r_v_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mem got w=%b r=%b exp 0/0", rf_if.mem_w_v_o, rf_if.mem_r_v_o);
    end
    tick();
    tick();
    checks++;
    if (rf_if.r_v_o !== 1'b0 || rf_if.r_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got v=%b rdy=%b exp v=0 rdy=1", rf_if.r_v_o, rf_if.r_ready_o);
    end
    checks++;
    if (rf_if.rs1_data_o !== 32'd0 || rf_if.rs2_data_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got %h/%h exp 0/0", rf_if.rs1_data_o, rf_if.rs2_data_o);
    end
    clear_inputs();
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_write(5'd5, 32'hDEAD_BEEF);
    do_write(5'd9, 32'h1234_5678);
    rf_if.r_v_i      = 1'b1;
    rf_if.rs1_addr_i = 5'd5;
    rf_if.rs2_addr_i = 5'd9;
    #1;
    checks++;
    if (rf_if.mem_r_v_o !== 1'b1 || rf_if.mem_r_addr_o !== 5'd5 || rf_if.r_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL basic_rd1 got v=%b a=%0d rdy=%b exp 1/5/1", rf_if.mem_r_v_o, rf_if.mem_r_addr_o, rf_if.r_ready_o);
    end
    tick();
    rf_if.r_v_i      = 1'b0;
    rf_if.rs1_addr_i = 5'd31;
    rf_if.rs2_addr_i = 5'd31;
    #1;
    checks++;
    if (rf_if.mem_r_v_o !== 1'b1 || rf_if.mem_r_addr_o !== 5'd9 || rf_if.r_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_rd2 got v=%b a=%0d rdy=%b exp 1/9/0", rf_if.mem_r_v_o, rf_if.mem_r_addr_o, rf_if.r_ready_o);
    end
    tick();
    checks++;
    if (rf_if.r_v_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_early got v=%b exp 0", rf_if.r_v_o);
    end
    tick();
    checks++;
    if (rf_if.r_v_o !== 1'b1 || rf_if.rs1_data_o !== 32'hDEAD_BEEF || rf_if.rs2_data_o !== 32'h1234_5678) begin
      failures++;
      $display("FAIL basic_resp got v=%b %h/%h exp 1 deadbeef/12345678", rf_if.r_v_o, rf_if.rs1_data_o, rf_if.rs2_data_o);
    end
    consume("basic");
  endtask

  task automatic test_zero();
    do_write(5'd0, 32'hFFFF_FFFF);
    rf_if.r_v_i      = 1'b1;
    rf_if.rs1_addr_i = 5'd0;
    rf_if.rs2_addr_i = 5'd0;
    #1;
    checks++;
    if (rf_if.mem_r_v_o !== 1'b0) begin
      failures++;
      $display("FAIL zero_rd1 got v=%b exp 0", rf_if.mem_r_v_o);
    end
    tick();
    rf_if.r_v_i = 1'b0;
    #1;
    checks++;
    if (rf_if.mem_r_v_o !== 1'b0) begin
      failures++;
      $display("FAIL zero_rd2 got v=%b exp 0", rf_if.mem_r_v_o);
    end
    tick();
    tick();
    checks++;
    if (rf_if.r_v_o !== 1'b1 || rf_if.rs1_data_o !== 32'd0 || rf_if.rs2_data_o !== 32'd0) begin
      failures++;
      $display("FAIL zero_resp got v=%b %h/%h exp 1 0/0", rf_if.r_v_o, rf_if.rs1_data_o, rf_if.rs2_data_o);
    end
    consume("zero");
  endtask

  // Collision forward at accept, forward into rs2 at CAP, then a long hold in RESP.
  task automatic test_collision_and_hold();
    rf_if.r_v_i      = 1'b1;
    rf_if.rs1_addr_i = 5'd7;
    rf_if.rs2_addr_i = 5'd3;
    rf_if.w_v_i      = 1'b1;
    rf_if.w_addr_i   = 5'd7;
    rf_if.w_data_i   = 32'hAAAA_0001;
    #1;
    checks++;
    if (rf_if.mem_r_v_o !== 1'b1 || rf_if.mem_r_addr_o !== 5'd7 || rf_if.mem_w_v_o !== 1'b1) begin
      failures++;
      $display("FAIL coll_issue got r=%b a=%0d w=%b exp 1/7/1", rf_if.mem_r_v_o, rf_if.mem_r_addr_o, rf_if.mem_w_v_o);
    end
    tick();
    clear_inputs();
    tick();
    rf_if.w_v_i    = 1'b1;
    rf_if.w_addr_i = 5'd3;
    rf_if.w_data_i = 32'hBBBB_0002;
    tick();
    rf_if.w_v_i = 1'b0;
    checks++;
    if (rf_if.r_v_o !== 1'b1 || rf_if.rs1_data_o !== 32'hAAAA_0001 || rf_if.rs2_data_o !== 32'hBBBB_0002) begin
      failures++;
      $display("FAIL coll_resp got v=%b %h/%h exp 1 aaaa0001/bbbb0002", rf_if.r_v_o, rf_if.rs1_data_o, rf_if.rs2_data_o);
    end
    for (int i = 0; i < 5; i++) begin
      rf_if.w_v_i    = 1'b1;
      rf_if.w_addr_i = 5'd7;
      rf_if.w_data_i = 32'h0;
      tick();
      checks++;
      if (rf_if.r_v_o !== 1'b1 || rf_if.r_ready_o !== 1'b0 ||
          rf_if.rs1_data_o !== 32'hAAAA_0001 || rf_if.rs2_data_o !== 32'hBBBB_0002) begin
        failures++;
        $display("FAIL hold_%0d got v=%b rdy=%b %h/%h exp 1/0 aaaa0001/bbbb0002", i,
                 rf_if.r_v_o, rf_if.r_ready_o, rf_if.rs1_data_o, rf_if.rs2_data_o);
      end
    end
    rf_if.w_v_i = 1'b0;
    consume("hold");
  endtask

  task automatic test_reset_mid();
    accept(5'd5, 5'd9);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checks++;
    if (rf_if.r_v_o !== 1'b0 || rf_if.r_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_after got v=%b rdy=%b exp 0/1", rf_if.r_v_o, rf_if.r_ready_o);
    end
    tick();
    tick();
    tick();
    checks++;
    if (rf_if.r_v_o !== 1'b0 || rf_if.r_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_noresp got v=%b rdy=%b exp 0/1", rf_if.r_v_o, rf_if.r_ready_o);
    end
    accept(5'd9, 5'd5);
    tick();
    tick();
    checks++;
    if (rf_if.r_v_o !== 1'b1 || rf_if.rs1_data_o !== 32'h1234_5678 || rf_if.rs2_data_o !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rstmid_fresh got v=%b %h/%h exp 1 12345678/deadbeef", rf_if.r_v_o, rf_if.rs1_data_o, rf_if.rs2_data_o);
    end
    consume("rstmid");
  endtask

  task automatic test_same_addr();
    logic exp_rd2_v;
`ifdef BRG_RF_SEQ_SAME_ADDR_SKIP_EN
    exp_rd2_v = 1'b0;
`else
    exp_rd2_v = 1'b1;
`endif
    do_write(5'd12, 32'h0F0F_0F0F);
    rf_if.r_v_i      = 1'b1;
    rf_if.rs1_addr_i = 5'd12;
    rf_if.rs2_addr_i = 5'd12;
    #1;
    checks++;
    if (rf_if.mem_r_v_o !== 1'b1 || rf_if.mem_r_addr_o !== 5'd12) begin
      failures++;
      $display("FAIL same_rd1 got v=%b a=%0d exp 1/12", rf_if.mem_r_v_o, rf_if.mem_r_addr_o);
    end
    tick();
    rf_if.r_v_i = 1'b0;
    #1;
    checks++;
    if (rf_if.mem_r_v_o !== exp_rd2_v) begin
      failures++;
      $display("FAIL same_rd2 got v=%b exp %b", rf_if.mem_r_v_o, exp_rd2_v);
    end
    tick();
    tick();
    checks++;
    if (rf_if.r_v_o !== 1'b1 || rf_if.rs1_data_o !== 32'h0F0F_0F0F || rf_if.rs2_data_o !== 32'h0F0F_0F0F) begin
      failures++;
      $display("FAIL same_resp got v=%b %h/%h exp 1 0f0f0f0f/0f0f0f0f", rf_if.r_v_o, rf_if.rs1_data_o, rf_if.rs2_data_o);
    end
    consume("same");
    // Forward during RD2 must reach both copies of the operand.
    accept(5'd12, 5'd12);
    rf_if.w_v_i    = 1'b1;
    rf_if.w_addr_i = 5'd12;
    rf_if.w_data_i = 32'h55AA_55AA;
    tick();
    rf_if.w_v_i = 1'b0;
    tick();
    checks++;
    if (rf_if.r_v_o !== 1'b1 || rf_if.rs1_data_o !== 32'h55AA_55AA || rf_if.rs2_data_o !== 32'h55AA_55AA) begin
      failures++;
      $display("FAIL same_fwd got v=%b %h/%h exp 1 55aa55aa/55aa55aa", rf_if.r_v_o, rf_if.rs1_data_o, rf_if.rs2_data_o);
    end
    consume("same_fwd");
  endtask

  task automatic test_back_to_back();
    accept(5'd9, 5'd5);
    tick();
    tick();
    checks++;
    if (rf_if.r_v_o !== 1'b1 || rf_if.rs1_data_o !== 32'h1234_5678 || rf_if.rs2_data_o !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL b2b_first got v=%b %h/%h exp 1 12345678/deadbeef", rf_if.r_v_o, rf_if.rs1_data_o, rf_if.rs2_data_o);
    end
    rf_if.r_yumi_i = 1'b1;
    tick();
    rf_if.r_yumi_i = 1'b0;
    checks++;
    if (rf_if.r_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready got rdy=%b exp 1", rf_if.r_ready_o);
    end
    accept(5'd5, 5'd9);
    tick();
    // rs1 was already captured from the macro in RD2; a CAP-cycle write must overwrite it.
    rf_if.w_v_i    = 1'b1;
    rf_if.w_addr_i = 5'd5;
    rf_if.w_data_i = 32'h7777_8888;
    tick();
    rf_if.w_v_i = 1'b0;
    checks++;
    if (rf_if.r_v_o !== 1'b1 || rf_if.rs1_data_o !== 32'h7777_8888 || rf_if.rs2_data_o !== 32'h1234_5678) begin
      failures++;
      $display("FAIL b2b_second got v=%b %h/%h exp 1 77778888/12345678", rf_if.r_v_o, rf_if.rs1_data_o, rf_if.rs2_data_o);
    end
    consume("b2b");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    rf_if.mem_r_data_i = 32'd0;
    clear_inputs();
    reset_i = 1'b1;
    test_reset();
    test_basic();
    test_zero();
    test_collision_and_hold();
    test_reset_mid();
    test_same_addr();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

endmodule
